reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/reg_scoreboard.sv | 70 +++++++
 rtl/reg_file_sb.sv | 100 ++++++++++
 tb/tb_reg_file_sb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the register file with scoreboard.
// Holds the architectural register index type, the ABI index names and
// a helper that decides whether an index refers to a real, writable register.
package reg_file_pkg;

    localparam int ABI_IDX_W = 5;

    typedef logic [ABI_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO = 5'd0;
    localparam reg_idx_t RA   = 5'd1;
    localparam reg_idx_t SP   = 5'd2;
    localparam reg_idx_t GP   = 5'd3;
    localparam reg_idx_t TP   = 5'd4;

    // Index 0 and indices past the end of the file behave identically:
    // they read as zero, never go busy, and swallow writes and issues.
    function automatic logic idx_live(input logic [31:0] idx, input int count);
        return (idx != 32'(ZERO)) && (idx < 32'(count));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, WAW issue stall and
// a running count of pending registers kept in step with the busy bits.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int REG_SIZE  = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [REG_SIZE-1:0]  issue_rd,
    input  logic                 wen,
    input  logic [REG_SIZE-1:0]  wr_addr,
    output logic                 issue_ready,
    output logic [REG_COUNT-1:0] busy,
    output logic [REG_SIZE:0]    busy_count
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [REG_SIZE:0]    busy_count_q;
    logic [REG_SIZE:0]    busy_count_d;
    logic                 issue_live;
    logic                 wr_live;
    logic                 set_en;
    logic                 clr_en;

    // Decide which bit is set or cleared this cycle and the matching count step.
    always_comb begin
        issue_live   = idx_live(32'(issue_rd), REG_COUNT);
        wr_live      = idx_live(32'(wr_addr), REG_COUNT);
        issue_ready  = !(issue_live && busy_q[issue_rd]);
        set_en       = issue_valid && issue_live && issue_ready;
        // A writeback never clears a bit that a same-cycle issue targets,
        // so issue wins even when the issue itself is stalled.
        clr_en       = wen && wr_live && busy_q[wr_addr]
                       && !(issue_valid && (issue_rd == wr_addr));
        busy_d       = busy_q;
        busy_count_d = busy_count_q;
        if (clr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        // set_en only fires on a clear bit and clr_en only on a set bit,
        // so each one moves popcount by exactly one.
        case ({set_en, clr_en})
            2'b10:   busy_count_d = busy_count_q + (REG_SIZE+1)'(1);
            2'b01:   busy_count_d = busy_count_q - (REG_SIZE+1)'(1);
            default: busy_count_d = busy_count_q;
        endcase
    end

    // Busy bits and pending count, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = busy_count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with registered multi-port reads and an attached scoreboard.
// Optional feature macro REG_FILE_BYPASS_EN: when defined, a same-cycle
// writeback to a read index is forwarded to that port and its busy flag
// reads 0; when undefined, reads return the pre-write value and busy bit.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int NUM_RD     = 2,
    parameter int REG_SIZE   = $clog2(REG_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*REG_SIZE-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wen,
    input  logic [REG_SIZE-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         issue_valid,
    input  logic [REG_SIZE-1:0]          issue_rd,
    output logic                         issue_ready,
    output logic [REG_SIZE:0]            busy_count
);

    logic [DATA_WIDTH-1:0]        regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]        regs_d [REG_COUNT];
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;
    logic [NUM_RD-1:0]            rd_busy_q;
    logic [NUM_RD-1:0]            rd_busy_d;
    logic [REG_SIZE-1:0]          rd_idx [NUM_RD];
    logic [REG_COUNT-1:0]         busy_vec;
    logic                         wr_commit;

    reg_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .REG_SIZE  (REG_SIZE)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wen         (wen),
        .wr_addr     (wr_addr),
        .issue_ready (issue_ready),
        .busy        (busy_vec),
        .busy_count  (busy_count)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_idx
        assign rd_idx[g] = rd_addr[g*REG_SIZE +: REG_SIZE];
    end

    assign wr_commit = wen && idx_live(32'(wr_addr), REG_COUNT);

    // Next storage contents: only real nonzero registers take writes.
    always_comb begin
        regs_d = regs_q;
        if (wr_commit) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Next read-port data and busy flags, looked up from pre-edge state.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (idx_live(32'(rd_idx[i]), REG_COUNT)) begin
                rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_idx[i]];
                rd_busy_d[i]                          = busy_vec[rd_idx[i]];
`ifdef REG_FILE_BYPASS_EN
                if (wr_commit && (wr_addr == rd_idx[i])) begin
                    rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                    rd_busy_d[i]                          = 1'b0;
                end
`endif
            end
        end
    end

    // Storage and registered read ports, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized bench for reg_file_sb with a behavioural model
// (register array plus busy-bit array; pending count derived by popcount).
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int NR = 2;
    localparam int RS = 5;

    logic             clk;
    logic             rst;
    logic [NR*RS-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wen;
    logic [RS-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             issue_valid;
    logic [RS-1:0]    issue_rd;
    logic             issue_ready;
    logic [RS:0]      busy_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_regs [RC];
    bit            m_busy [RC];
    logic          seen_ready;

    reg_file_sb #(
        .DATA_WIDTH (DW),
        .REG_COUNT  (RC),
        .NUM_RD     (NR),
        .REG_SIZE   (RS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wen         (wen),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .busy_count  (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pending();
        int n = 0;
        for (int r = 0; r < RC; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < RC; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // One clock of traffic: drive, check issue_ready pre-edge, then check
    // the registered read ports and pending count after the edge.
    task automatic step(input bit w, input int wa, input logic [31:0] wd,
                        input bit iv, input int ir, input int ra0, input int ra1);
        logic [DW-1:0] e_rd [NR];
        bit            e_bz [NR];
        int            ra   [NR];
        bit            e_ready;
        @(negedge clk);
        wen         = w;
        wr_addr     = wa[RS-1:0];
        wr_data     = wd;
        issue_valid = iv;
        issue_rd    = ir[RS-1:0];
        rd_addr     = {ra1[RS-1:0], ra0[RS-1:0]};
        #1;
        e_ready    = !m_busy[ir];
        seen_ready = issue_ready;
        check("issue_ready", {63'd0, issue_ready}, {63'd0, e_ready});
        ra[0] = ra0;
        ra[1] = ra1;
        for (int i = 0; i < NR; i++) begin
            e_rd[i] = '0;
            e_bz[i] = 1'b0;
            if (ra[i] != 0) begin
                e_rd[i] = m_regs[ra[i]];
                e_bz[i] = m_busy[ra[i]];
`ifdef REG_FILE_BYPASS_EN
                if (w && wa == ra[i]) begin
                    e_rd[i] = wd;
                    e_bz[i] = 1'b0;
                end
`endif
            end
        end
        if (w && wa != 0) begin
            m_regs[wa] = wd;
            if (!(iv && ir == wa)) m_busy[wa] = 1'b0;
        end
        if (iv && e_ready && ir != 0) m_busy[ir] = 1'b1;
        @(posedge clk);
        #1;
        check("rd_data0", {32'd0, rd_data[31:0]}, {32'd0, e_rd[0]});
        check("rd_data1", {32'd0, rd_data[63:32]}, {32'd0, e_rd[1]});
        check("rd_busy0", {63'd0, rd_busy[0]}, {63'd0, e_bz[0]});
        check("rd_busy1", {63'd0, rd_busy[1]}, {63'd0, e_bz[1]});
        check("busy_count", {58'd0, busy_count}, 64'(model_pending()));
    endtask

    initial begin
        rst         = 1'b1;
        wen         = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rd_addr     = '0;
        model_clear();
        #1;
        check("reset_rd_data", {rd_data}, 64'd0);
        check("reset_rd_busy", {62'd0, rd_busy}, 64'd0);
        check("reset_busy_count", {58'd0, busy_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // x5 write then read
        step(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        step(0, 0, 32'h0, 0, 0, 5, 0);
        check("x5_readback", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);

        // x0 write and issue are inert
        step(1, 0, 32'h1234, 1, 0, 0, 0);
        check("x0_issue_ready", {63'd0, seen_ready}, 64'd1);
        check("x0_read", {32'd0, rd_data[31:0]}, 64'd0);
        check("x0_busy_count", {58'd0, busy_count}, 64'd0);

        // WAW stall on x7, then writeback clears it
        step(0, 0, 32'h0, 1, 7, 0, 0);
        check("x7_count_set", {58'd0, busy_count}, 64'd1);
        step(0, 0, 32'h0, 1, 7, 7, 0);
        check("x7_second_ready", {63'd0, seen_ready}, 64'd0);
        check("x7_count_hold", {58'd0, busy_count}, 64'd1);
        step(1, 7, 32'h55, 0, 0, 0, 7);
        check("x7_count_clear", {58'd0, busy_count}, 64'd0);

        // same-cycle write and read of x3
        step(1, 3, 32'h11, 0, 0, 0, 0);
        step(1, 3, 32'hAA, 0, 0, 0, 3);
`ifdef REG_FILE_BYPASS_EN
        check("x3_same_cycle", {32'd0, rd_data[63:32]}, 64'hAA);
`else
        check("x3_same_cycle", {32'd0, rd_data[63:32]}, 64'h11);
`endif

        // issue and writeback to busy x9 together: stays busy
        step(0, 0, 32'h0, 1, 9, 0, 0);
        step(1, 9, 32'h99, 1, 9, 0, 0);
        check("x9_count_same", {58'd0, busy_count}, 64'd1);
        step(0, 0, 32'h0, 0, 0, 9, 0);
        check("x9_still_busy", {63'd0, rd_busy[0]}, 64'd1);

        // issue x4, x6 then reset mid-cycle
        step(0, 0, 32'h0, 1, 4, 0, 0);
        step(0, 0, 32'h0, 1, 6, 4, 6);
        check("pre_reset_count", {58'd0, busy_count}, 64'd3);
        @(negedge clk);
        wen         = 1'b1;
        wr_addr     = 5'd12;
        wr_data     = 32'hCAFE;
        issue_valid = 1'b1;
        issue_rd    = 5'd13;
        rd_addr     = {5'd5, 5'd4};
        #2;
        rst = 1'b1;
        #1;
        check("async_rd_data", rd_data, 64'd0);
        check("async_rd_busy", {62'd0, rd_busy}, 64'd0);
        check("async_busy_count", {58'd0, busy_count}, 64'd0);
        @(posedge clk);
        #1;
        check("held_rd_data", rd_data, 64'd0);
        check("held_busy_count", {58'd0, busy_count}, 64'd0);
        @(negedge clk);
        rst         = 1'b0;
        wen         = 1'b0;
        issue_valid = 1'b0;
        model_clear();
        step(0, 0, 32'h0, 0, 0, 12, 5);
        check("post_reset_count", {58'd0, busy_count}, 64'd0);
        step(0, 0, 32'h0, 1, 4, 4, 13);

        // randomized traffic on a narrow index window to force collisions
        for (int n = 0; n < 400; n++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
        end

        // drain all pending registers
        for (int r = 1; r < 8; r++) begin
            step(1, r, 32'(r * 3), 0, 0, r, 0);
        end
        check("drained_count", {58'd0, busy_count}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
